// File: rtl/uart_pkg.sv
// Shared UART constants, state encoding and parity helper for the TX/RX pair.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS   = 8;
  localparam logic        UART_START_BIT   = 1'b0;
  localparam logic        UART_STOP_BIT    = 1'b1;
  localparam logic        UART_PARITY_EVEN = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_state_t;

  // Parity bit the sender is expected to place after the data bits.
  function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data);
    return (^data) ^ ~UART_PARITY_EVEN;
  endfunction

endpackage

// File: rtl/uart_sipo.sv
// Serial-in parallel-out shifter; bits arrive LSB first and enter at the MSB end.
module uart_sipo
  import uart_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      shift,
  input  logic                      bit_in,
  output logic [UART_DATA_BITS-1:0] data
);

  // Shift one serial bit in per strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
    end else if (shift) begin
      data <= {bit_in, data[UART_DATA_BITS-1:1]};
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start, 8 data bits LSB first, even parity, stop; flags parity/framing errors.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_in,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      rx_valid,
  output logic                      parity_err,
  output logic                      frame_err,
  output logic                      rx_busy
);

  localparam int unsigned CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF      = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_t                state;
  logic [CNT_W-1:0]           cnt;
  logic [2:0]                 bit_cnt;
  logic                       par_err_r;
  logic [UART_DATA_BITS-1:0]  sipo_data;
  logic                       tick_c;
  logic                       shift_c;

  // Sample point: the bit-interval counter is about to wrap.
  assign tick_c  = (cnt == CNT_LAST);
  assign shift_c = (state == DATA) && tick_c;

  uart_sipo u_sipo (
    .clk    (clk),
    .reset  (reset),
    .shift  (shift_c),
    .bit_in (rx_in),
    .data   (sipo_data)
  );

  // Frame sequencing with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      par_err_r  <= 1'b0;
      data_out   <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (rx_in == UART_START_BIT) begin
            rx_busy <= 1'b1;
            // With no half-bit offset the detection edge is already mid-bit.
            state   <= (HALF == 0) ? DATA : START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_in == UART_START_BIT) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (tick_c) begin
            cnt     <= '0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == BIT_LAST) begin
              state <= PARITY;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (tick_c) begin
            cnt       <= '0;
            par_err_r <= rx_in ^ calc_parity(sipo_data);
            state     <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (tick_c) begin
            cnt        <= '0;
            data_out   <= sipo_data;
            parity_err <= par_err_r;
            frame_err  <= (rx_in != UART_STOP_BIT);
            rx_valid   <= 1'b1;
            if (rx_in == UART_STOP_BIT) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          // Hold off until the line returns high so a break is not read as start bits.
          cnt <= '0;
          if (rx_in == UART_STOP_BIT) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at CLKS_PER_BIT=1 and CLKS_PER_BIT=4.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx1, rx4;
  logic [7:0] d1, d4;
  logic       v1, v4, pe1, pe4, fe1, fe4, b1, b4;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct packed {
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  rec_t obs1[$], obs4[$], exp1[$], exp4[$];

  uart_receiver #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .rx_in(rx1), .data_out(d1), .rx_valid(v1),
    .parity_err(pe1), .frame_err(fe1), .rx_busy(b1)
  );

  uart_receiver #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .rx_in(rx4), .data_out(d4), .rx_valid(v4),
    .parity_err(pe4), .frame_err(fe4), .rx_busy(b4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every cycle in which rx_valid is seen high.
  always @(negedge clk) begin
    rec_t r;
    if (v1 === 1'b1) begin
      r.cyc = cyc; r.d = d1; r.pe = pe1; r.fe = fe1;
      obs1.push_back(r);
    end
    if (v4 === 1'b1) begin
      r.cyc = cyc; r.d = d4; r.pe = pe4; r.fe = fe4;
      obs4.push_back(r);
    end
  end

  task automatic drive(input int which, input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which == 1) rx1 = b; else rx4 = b;
    end
  endtask

  // Send one frame and queue the outcome the protocol predicts for it.
  task automatic send_frame(input int which, input logic [7:0] d, input logic bad_par,
                            input logic stop);
    int   cpb;
    int   h;
    int   t;
    logic p;
    rec_t e;
    cpb = (which == 1) ? 1 : 4;
    h   = (cpb - 1) / 2;
    p   = (^d) ^ bad_par;
    @(negedge clk);
    if (which == 1) rx1 = 1'b0; else rx4 = 1'b0;
    t = cyc + 1;
    drive(which, 1'b0, cpb - 1);
    for (int k = 0; k < 8; k++) drive(which, d[k], cpb);
    drive(which, p, cpb);
    drive(which, stop, cpb);
    e.cyc = t + 10 * cpb + h;
    e.d   = d;
    e.pe  = p ^ (^d);
    e.fe  = (stop == 1'b0);
    if (which == 1) exp1.push_back(e); else exp4.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx1 = 1'b1;
    rx4 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (d1 !== 8'h00) begin failures++; $display("FAIL reset_data1 got %h want 00", d1); end
    checks++; if (v1 !== 1'b0)  begin failures++; $display("FAIL reset_valid1 got %b want 0", v1); end
    checks++; if (pe1 !== 1'b0) begin failures++; $display("FAIL reset_perr1 got %b want 0", pe1); end
    checks++; if (fe1 !== 1'b0) begin failures++; $display("FAIL reset_ferr1 got %b want 0", fe1); end
    checks++; if (b1 !== 1'b0)  begin failures++; $display("FAIL reset_busy1 got %b want 0", b1); end
    checks++; if (d4 !== 8'h00) begin failures++; $display("FAIL reset_data4 got %h want 00", d4); end
    checks++; if (v4 !== 1'b0)  begin failures++; $display("FAIL reset_valid4 got %b want 0", v4); end
    checks++; if (b4 !== 1'b0)  begin failures++; $display("FAIL reset_busy4 got %b want 0", b4); end
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1'b1, 3);
  endtask

  task automatic test_basic();
    rec_t o, e;
    send_frame(1, 8'hA5, 1'b0, 1'b1);
    drive(1, 1'b1, 2);
    send_frame(1, 8'h3C, 1'b1, 1'b1);
    drive(1, 1'b1, 1);
    send_frame(1, 8'h01, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'b1, $urandom_range(0, 3));
      send_frame(1, 8'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
    end
    drive(1, 1'b1, 6);
    checks++;
    if (d1 !== exp1[exp1.size()-1].d) begin
      failures++; $display("FAIL basic_hold got %h want %h", d1, exp1[exp1.size()-1].d);
    end
    checks++;
    if (obs1.size() != exp1.size()) begin
      failures++; $display("FAIL basic_count got %0d want %0d", obs1.size(), exp1.size());
    end
    while (obs1.size() > 0 && exp1.size() > 0) begin
      o = obs1.pop_front(); e = exp1.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL basic_frame got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b",
                 o.cyc, o.d, o.pe, o.fe, e.cyc, e.d, e.pe, e.fe);
      end
    end
    obs1.delete(); exp1.delete();
  endtask

  task automatic test_frame_err();
    rec_t o, e;
    send_frame(1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'b0, 1);
      checks++;
      if (b1 !== 1'b1) begin failures++; $display("FAIL ferr_busy_low got %b want 1", b1); end
    end
    drive(1, 1'b1, 1);
    checks++;
    if (b1 !== 1'b1) begin failures++; $display("FAIL ferr_busy_last got %b want 1", b1); end
    @(negedge clk);
    checks++;
    if (b1 !== 1'b0) begin failures++; $display("FAIL ferr_busy_release got %b want 0", b1); end
    drive(1, 1'b1, 15);
    checks++;
    if (obs1.size() != exp1.size()) begin
      failures++; $display("FAIL ferr_count got %0d want %0d", obs1.size(), exp1.size());
    end
    while (obs1.size() > 0 && exp1.size() > 0) begin
      o = obs1.pop_front(); e = exp1.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL ferr_frame got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b",
                 o.cyc, o.d, o.pe, o.fe, e.cyc, e.d, e.pe, e.fe);
      end
    end
    obs1.delete(); exp1.delete();
  endtask

  task automatic test_back_to_back();
    rec_t o, e;
    send_frame(1, 8'h00, 1'b0, 1'b1);
    send_frame(1, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send_frame(1, 8'($urandom), 1'b0, 1'b1);
    end
    drive(1, 1'b1, 6);
    checks++;
    if (obs1.size() != exp1.size()) begin
      failures++; $display("FAIL b2b_count got %0d want %0d", obs1.size(), exp1.size());
    end
    while (obs1.size() > 0 && exp1.size() > 0) begin
      o = obs1.pop_front(); e = exp1.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_frame got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b",
                 o.cyc, o.d, o.pe, o.fe, e.cyc, e.d, e.pe, e.fe);
      end
    end
    obs1.delete(); exp1.delete();
  endtask

  task automatic test_reset_midframe();
    rec_t       o, e;
    logic [7:0] part;
    part = 8'hA7;
    send_frame(1, 8'h3C, 1'b1, 1'b1);
    drive(1, 1'b1, 3);
    checks++;
    if (d1 !== 8'h3C || pe1 !== 1'b1) begin
      failures++; $display("FAIL pre_reset got d=%h pe=%b want d=3c pe=1", d1, pe1);
    end
    obs1.delete(); exp1.delete();
    drive(1, 1'b0, 1);
    for (int k = 0; k <= 4; k++) drive(1, part[k], 1);
    @(negedge clk);
    checks++;
    if (b1 !== 1'b1) begin failures++; $display("FAIL midframe_busy got %b want 1", b1); end
    reset = 1'b0;
    #1;
    checks++;
    if ({d1, v1, pe1, fe1, b1} !== 12'h000) begin
      failures++;
      $display("FAIL async_reset got d=%h v=%b pe=%b fe=%b busy=%b want all 0", d1, v1, pe1, fe1, b1);
    end
    drive(1, 1'b1, 2);
    reset = 1'b1;
    drive(1, 1'b1, 2);
    send_frame(1, 8'h81, 1'b0, 1'b1);
    drive(1, 1'b1, 6);
    checks++;
    if (obs1.size() != exp1.size()) begin
      failures++; $display("FAIL rst_count got %0d want %0d", obs1.size(), exp1.size());
    end
    while (obs1.size() > 0 && exp1.size() > 0) begin
      o = obs1.pop_front(); e = exp1.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rst_frame got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b",
                 o.cyc, o.d, o.pe, o.fe, e.cyc, e.d, e.pe, e.fe);
      end
    end
    obs1.delete(); exp1.delete();
  endtask

  task automatic test_slow();
    rec_t o, e;
    drive(4, 1'b1, 4);
    drive(4, 1'b0, 1);
    drive(4, 1'b1, 1);
    checks++;
    if (b4 !== 1'b1) begin failures++; $display("FAIL glitch_busy_rise got %b want 1", b4); end
    @(negedge clk);
    checks++;
    if (b4 !== 1'b0) begin failures++; $display("FAIL glitch_busy_fall got %b want 0", b4); end
    drive(4, 1'b1, 12);
    checks++;
    if (obs4.size() != 0) begin
      failures++; $display("FAIL glitch_valid got %0d frames want 0", obs4.size());
    end
    obs4.delete();
    send_frame(4, 8'hC3, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(4, 1'b1, $urandom_range(0, 5));
      send_frame(4, 8'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) != 0));
      drive(4, 1'b1, 1);
    end
    drive(4, 1'b1, 12);
    checks++;
    if (obs4.size() != exp4.size()) begin
      failures++; $display("FAIL slow_count got %0d want %0d", obs4.size(), exp4.size());
    end
    while (obs4.size() > 0 && exp4.size() > 0) begin
      o = obs4.pop_front(); e = exp4.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL slow_frame got cyc=%0d d=%h pe=%b fe=%b want cyc=%0d d=%h pe=%b fe=%b",
                 o.cyc, o.d, o.pe, o.fe, e.cyc, e.d, e.pe, e.fe);
      end
    end
    obs4.delete(); exp4.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_slow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
